// File: rtl/sd_tx_fifo.sv
// -----------------------------------------------------------------------------
// sd_tx_fifo
//
// Synchronous transmit FIFO sitting between the host/DMA side and the SD
// data-line serializer. The DMA pushes nibbles; the serializer pops them.
// One clock domain (wclk) for both sides.
//
// Optional feature macro: SD_TX_FIFO_ERR_EN
//   defined   -> adds output 'err', a sticky overflow/underflow flag that
//                only rst clears.
//   undefined -> no 'err' port; illegal strobes are silently ignored.
//
// Ports
//   wclk      in   1    clock for both write and read sides
//   rst       in   1    synchronous reset, active-low (0 = reset)
//   d         in   DW   write data
//   wr        in   1    write strobe
//   q         out  DW   head-of-FIFO data, first-word-fall-through (0 while empty)
//   rd        in   1    read strobe
//   full      out  1    count == DEPTH
//   empty     out  1    count == 0
//   mem_empt  out  2    fill hint: [1] count < DEPTH/2, [0] count <= 1
//   err       out  1    sticky error flag (only with SD_TX_FIFO_ERR_EN)
//
// Handshake: the writer side treats !full as ready and wr as valid; a word is
// transferred at the rising edge where wr && !full. The reader side treats
// !empty as valid and rd as ready; q is the word offered, and it is consumed
// at the rising edge where rd && !empty. Strobes outside those conditions
// have no effect on storage, pointers or count.
// -----------------------------------------------------------------------------
module sd_tx_fifo #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          wclk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          wr,
  output logic [DW-1:0] q,
  input  logic          rd,
  output logic          full,
  output logic          empty,
  output logic [1:0]    mem_empt
`ifdef SD_TX_FIFO_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int DEPTH = 1 << AW;

  // count == DEPTH is exactly the MSB of the (AW+1)-bit counter set.
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic          push;
  logic          pop;
  logic [AW:0]   count_next;

  // Qualified transfers. Flags come from the registered count, so a strobe
  // against a full/empty FIFO is simply dropped.
  assign push = wr && !full;
  assign pop  = rd && !empty;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Pointers and occupancy. Reset discards everything queued in the same
  // cycle; the array itself keeps stale data, which is never visible
  // because q is masked while empty.
  always_ff @(posedge wclk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage. Writes are suppressed during reset so a strobe coinciding with
  // reset cannot leave a word that a later pointer sweep would expose.
  always_ff @(posedge wclk) begin
    if (rst && push) mem[wptr] <= d;
  end

  // Status decode, all from the registered count.
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  // count < DEPTH/2 <=> the two top counter bits are both clear.
  assign mem_empt[1] = ~count[AW] & ~count[AW-1];
  // count <= 1 <=> every bit above bit 0 is clear.
  assign mem_empt[0] = (count[AW:1] == '0);

  // First-word-fall-through head, forced to zero when nothing is queued.
  assign q = empty ? '0 : mem[rptr];

`ifdef SD_TX_FIFO_ERR_EN
  // Sticky error: overflow (wr while full) or underflow (rd while empty).
  always_ff @(posedge wclk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((wr && full) || (rd && empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_tx_fifo.sv
module tb_sd_tx_fifo;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic          wclk;
  logic          rst;
  logic [DW-1:0] d;
  logic          wr;
  logic          rd;
  logic [DW-1:0] q;
  logic          full;
  logic          empty;
  logic [1:0]    mem_empt;
`ifdef SD_TX_FIFO_ERR_EN
  logic          err;
`endif

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  sd_tx_fifo #(.DW(DW), .AW(AW)) dut (
    .wclk     (wclk),
    .rst      (rst),
    .d        (d),
    .wr       (wr),
    .q        (q),
    .rd       (rd),
    .full     (full),
    .empty    (empty),
    .mem_empt (mem_empt)
`ifdef SD_TX_FIFO_ERR_EN
    ,
    .err      (err)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_err;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every observable output against the queue model.
  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".mem_empt"}, 32'(mem_empt), {30'd0, (n < DEPTH/2), (n <= 1)});
    check({tag, ".q"}, 32'(q), (n == 0) ? 32'd0 : 32'(exp_q[0]));
`ifdef SD_TX_FIFO_ERR_EN
    check({tag, ".err"}, 32'(err), 32'(exp_err));
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle with rst high: drive strobes, apply the FIFO rules to the
  // queue at the edge, then check shortly after the edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] data, input logic r);
    bit do_push, do_pop;
    rst = 1'b1; wr = w; d = data; rd = r;
    do_push = w && (exp_q.size() < DEPTH);
    do_pop  = r && (exp_q.size() > 0);
    if ((w && exp_q.size() == DEPTH) || (r && exp_q.size() == 0)) exp_err = 1'b1;
    @(posedge wclk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(data);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1'b0; wr = w; rd = r; d = 4'($urandom_range(0, 15));
    @(posedge wclk);
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    check_outputs("reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] pattern [16];
    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; d = '0;
    pattern = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hD, 4'hC,
                4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'hA, 4'hB};

    // 1: reset
    do_reset(1'b0, 1'b0);

    // 2: ordered data, write every other cycle, reader pops when non-empty
    for (int i = 0; i < 16; i++) begin
      step("order_wr", 1'b1, pattern[i], exp_q.size() > 0);
      step("order_gap", 1'b0, 4'h0, exp_q.size() > 0);
    end
    for (int i = 0; i < 3; i++) step("order_drain", 1'b0, 4'h0, exp_q.size() > 0);
    check("order_end_empty", 32'(empty), 32'd1);

    // 3 + 4: fill, overflow write dropped, drain; twice to cross the wrap
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 16; i++) step("fill_wr", 1'b1, 4'($urandom_range(0, 15)), 1'b0);
      check("fill_full", 32'(full), 32'd1);
      check("fill_mem_empt", 32'(mem_empt), 32'd0);
      step("fill_overflow", 1'b1, 4'h5, 1'b0);
      step("fill_overflow_rd", 1'b1, 4'h5, 1'b1);   // wr while full with rd: wr ignored
      for (int i = 0; i < 16; i++) step("fill_rd", 1'b0, 4'h0, 1'b1);
      check("fill_end_empty", 32'(empty), 32'd1);
    end

    // 5: simultaneous read/write at count 3, then at count 0
    for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < 4; i++) step("sim_rw", 1'b1, 4'($urandom_range(0, 15)), 1'b1);
    check("sim_count3", 32'(exp_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) step("sim_drain", 1'b0, 4'h0, 1'b1);
    step("sim_rw_empty", 1'b1, 4'h9, 1'b1);
    check("sim_q_after_empty_rw", 32'(q), 32'h9);
    step("sim_last", 1'b0, 4'h0, 1'b1);

`ifdef SD_TX_FIFO_ERR_EN
    // 6: underflow sets sticky err until reset
    step("err_underflow", 1'b0, 4'h0, 1'b1);
    check("err_set", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) step("err_sticky", 1'b1, 4'($urandom_range(0, 15)), 1'b1);
    do_reset(1'b0, 1'b0);
    check("err_cleared", 32'(err), 32'd0);
`endif

    // mid-stream reset discards queued data, even with strobes active
    for (int i = 0; i < 5; i++) step("mid_fill", 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    do_reset(1'b1, 1'b1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom), 1'($urandom));
      else step("rand", ($urandom_range(0, 99) < 55), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 99) < 45));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
